// File: rtl/ale_pkg.sv
// Shared definitions for the ALU and its round-robin front end.
// Opcode encodings and the sequencer state type live here.
package ale_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/ale.sv
// Combinational N-bit ALU; arithmetic wraps, shifts use the full N-bit b.
// Opcodes with bit 3 set produce zero.
module ale
    import ale_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [3:0]   op_i,
    output logic [N-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            // Shift counts of N or more naturally yield zero / sign fill.
            OP_SLL:  result_o = a_i << b_i;
            OP_SRL:  result_o = a_i >> b_i;
            OP_SRA:  result_o = $signed(a_i) >>> b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/ale_arbiter.sv
// Round-robin arbiter sharing one ale between NREQ requesters; one op per
// grant, result held on a tagged response channel until accepted.
module ale_arbiter
    import ale_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_result,
    output logic              rsp_illegal
);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [3:0]     op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]   rsp_result_q, rsp_result_d;
    logic           rsp_illegal_q, rsp_illegal_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] grant_next;
    logic [N-1:0]   alu_result;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned cand;
        logic [IDW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_next  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand     = (32'(rr_ptr_q) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
                grant_next  = IDW'((cand + 1) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        id_d          = id_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    a_d      = req_a[grant_idx*N +: N];
                    b_d      = req_b[grant_idx*N +: N];
                    op_d     = req_op[grant_idx*4 +: 4];
                    id_d     = grant_idx;
                    rr_ptr_d = grant_next;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d  = alu_result;
                rsp_id_d      = id_q;
                rsp_illegal_d = op_q[3];
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            id_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            id_q          <= id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    ale #(
        .N (N)
    ) u_ale (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result)
    );

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_ale_arbiter.sv
// Scoreboard bench for ale_arbiter: a grant/ALU reference model predicts
// req_ready and queues expected responses; a monitor checks the response port.
module tb_ale_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*4-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_result;
    logic              rsp_illegal;

    ale_arbiter #(
        .N    (N),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_illegal (rsp_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int result;
        int illegal;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    int   m_rr = 0;
    bit   m_busy = 1'b0;
    int   m_resp_cyc = 0;
    bit   hs_seen = 1'b0;
    int   hs_idx = -1;
    bit   drop_on_grant = 1'b1;
    int   grant_log[$];
    int   hs_cyc_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int ref_grant(input int rr, input logic [NREQ-1:0] v);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int ref_alu(input int a, input int b, input int op);
        int mask;
        int s;
        mask = (1 << N) - 1;
        s    = (a >> (N - 1)) & 1;
        case (op)
            0: return (a + b) & mask;
            1: return (a - b) & mask;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (b >= int'(N)) ? 0 : ((a << b) & mask);
            6: return (b >= int'(N)) ? 0 : (a >> b);
            7: begin
                if (b >= int'(N)) return (s != 0) ? mask : 0;
                if (s == 0) return a >> b;
                return ((a >> b) | (mask << (N - b))) & mask;
            end
            default: return 0;
        endcase
    endfunction

    // One clock: check/advance the model at the falling edge, then return
    // just after the next rising edge so the caller can change inputs.
    task automatic tick();
        int g;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        hs_seen = 1'b0;
        exp_rdy = '0;
        g       = -1;
        if (!rst && !m_busy) begin
            g = ref_grant(m_rr, req_valid);
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        if (rst) begin
            m_rr   = 0;
            m_busy = 1'b0;
            sb_q.delete();
        end else if (m_busy) begin
            if (cyc >= m_resp_cyc && rsp_ready) m_busy = 1'b0;
        end else if (g >= 0) begin
            hs_seen    = 1'b1;
            hs_idx     = g;
            m_busy     = 1'b1;
            m_resp_cyc = cyc + 2;
            m_rr       = (g + 1) % NREQ;
            e.id       = g;
            e.result   = ref_alu(int'(req_a[g*N +: N]), int'(req_b[g*N +: N]),
                                 int'(req_op[g*4 +: 4]));
            e.illegal  = (int'(req_op[g*4 +: 4]) >= 8) ? 1 : 0;
            e.cyc      = cyc + 2;
            sb_q.push_back(e);
            grant_log.push_back(g);
            hs_cyc_log.push_back(cyc);
        end
        @(posedge clk);
        #2;
        if (hs_seen && drop_on_grant) req_valid[hs_idx] = 1'b0;
    endtask

    task automatic wait_hs(input int max_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!hs_seen && n < max_cycles);
        if (!hs_seen) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant want a grant within %0d cycles",
                     max_cycles);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b, input int op);
        req_valid[i]       = 1'b1;
        req_a[i*N +: N]    = N'(a);
        req_b[i*N +: N]    = N'(b);
        req_op[i*4 +: 4]   = 4'(op);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: pops on each new response, checks latency and hold stability.
    exp_t cur_e;
    bit   held = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (!held) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d result %0d want no response",
                             rsp_id, rsp_result);
                end else begin
                    cur_e = sb_q.pop_front();
                    chk("rsp_id", int'(rsp_id), cur_e.id);
                    chk("rsp_result", int'(rsp_result), cur_e.result);
                    chk("rsp_illegal", int'(rsp_illegal), cur_e.illegal);
                    chk("rsp_latency", cyc, cur_e.cyc);
                end
            end else begin
                chk("hold_id", int'(rsp_id), cur_e.id);
                chk("hold_result", int'(rsp_result), cur_e.result);
                chk("hold_illegal", int'(rsp_illegal), cur_e.illegal);
            end
            held = !rsp_ready;
        end else begin
            held = 1'b0;
        end
    end

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int exp_t2_res[4] = '{15, 0, 1, 2};
    int bops[4][4] = '{'{7, 8, 5, 15}, '{5, 1, 4, 0}, '{9, 3, 2, 0}, '{6, 9, 4, 0}};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_rsp_result", int'(rsp_result), 0);
        chk("reset_rsp_illegal", int'(rsp_illegal), 0);

        // Single requester 2: 5 + 3.
        rsp_ready = 1'b1;
        set_req(2, 5, 3, 0);
        wait_hs(10);
        chk("t1_grant", hs_idx, 2);
        tick();
        chk("t1_result", int'(rsp_result), 8);
        chk("t1_id", int'(rsp_id), 2);
        repeat (3) tick();

        // All requesters continuously valid: a=i, b=1, SUB.
        do_reset();
        drop_on_grant = 1'b0;
        grant_log.delete();
        hs_cyc_log.delete();
        for (int i = 0; i < int'(NREQ); i++) set_req(i, i, 1, 1);
        repeat (16) tick();
        for (int k = 0; k < 5; k++) begin
            chk("t2_grant_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
        end
        for (int k = 1; k < 5; k++) begin
            chk("t2_spacing", (k < hs_cyc_log.size()) ? hs_cyc_log[k] - hs_cyc_log[k-1] : -1,
                3);
        end
        for (int k = 0; k < 4; k++) begin
            chk("t2_model_result", ref_alu(k, 1, 1), exp_t2_res[k]);
        end
        req_valid     = '0;
        drop_on_grant = 1'b1;
        repeat (4) tick();

        // Consumer stalls for five cycles while another requester waits.
        rsp_ready = 1'b0;
        set_req(0, 6, 7, 4);
        set_req(1, 2, 2, 0);
        wait_hs(10);
        repeat (2) tick();
        repeat (5) tick();
        chk("t3_rspv_held", int'(rsp_valid), 1);
        rsp_ready = 1'b1;
        tick();
        chk("t3_rspv_drop", int'(rsp_valid), 0);
        repeat (5) tick();

        // Boundary opcodes on requester 1.
        for (int k = 0; k < 4; k++) begin
            set_req(1, bops[k][1], bops[k][2], bops[k][0]);
            wait_hs(10);
            tick();
            chk("t4_result", int'(rsp_result), bops[k][3]);
            chk("t4_illegal", int'(rsp_illegal), (bops[k][0] >= 8) ? 1 : 0);
            repeat (3) tick();
        end

        // Reset while an op is executing: no response, pointer back to 0.
        set_req(2, 1, 1, 0);
        wait_hs(10);
        repeat (4) tick();
        drop_on_grant = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) set_req(i, i, 3, 2);
        wait_hs(10);
        chk("t5_pre_grant", hs_idx, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rspv_after_rst", int'(rsp_valid), 0);
        wait_hs(10);
        chk("t5_post_grant", hs_idx, 0);
        req_valid     = '0;
        drop_on_grant = 1'b1;
        repeat (5) tick();

        // Requester 1 withdraws before its turn; requester 3 wins from rr_ptr=1.
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 3, 3, 3);
        wait_hs(10);
        set_req(1, 4, 4, 0);
        set_req(3, 9, 2, 1);
        repeat (3) tick();
        req_valid[1] = 1'b0;
        rsp_ready    = 1'b1;
        wait_hs(10);
        chk("t6_grant", hs_idx, 3);
        for (int i = 0; i < int'(NREQ); i++) set_req(i, i + 2, 1, 0);
        wait_hs(10);
        chk("t6_next_grant", hs_idx, 0);
        req_valid = '0;
        repeat (5) tick();

        // Randomised traffic with random back-pressure and withdrawals.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 15)));
                end else if (req_valid[i] && $urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
